uart_alu_interface: RTL and testbench
=====================================

Name: uart_alu_interface

Overview:
- Downstream consumer of the UART receiver's `data_out`/`valid` pair.
- Assembles three received bytes into an ALU transaction, in order: operand A, operand B, opcode.
- Drives the combinational ALU with registered operands and opcode, captures the result, and hands it to the UART transmitter with a start/busy handshake.
- Sits between uart_rx, the ALU and uart_tx in the top-level of the TP2 datapath.

Parameters:
- DATA_WIDTH, 8: width of operands, result and UART bytes.
- OP_WIDTH, 6: opcode width; taken from the low OP_WIDTH bits of the opcode byte.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  DATA_WIDTH  byte from uart_rx `data_out`.
- rx_valid  input  1  uart_rx valid. May be held high for many clk cycles; only its rising edge counts.
- alu_a  output  DATA_WIDTH  registered operand A to the ALU.
- alu_b  output  DATA_WIDTH  registered operand B to the ALU.
- alu_op  output  OP_WIDTH  registered opcode to the ALU.
- alu_result  input  DATA_WIDTH  combinational ALU result.
- tx_data  output  DATA_WIDTH  byte to uart_tx; stable while tx_start is high.
- tx_start  output  1  one-cycle transmit request.
- tx_busy  input  1  uart_tx busy.
- op_err  output  1  one-cycle pulse when an opcode is not legal.
- overrun  output  1  sticky flag: a byte arrived while a result was pending. Cleared only by reset.

Behaviour:
- Reset values (synchronous, on clk edge with reset=1):
  - state=WAIT_A.
  - alu_a, alu_b, alu_op, tx_data, result_reg all 0.
  - tx_start, op_err, overrun all 0.
  - rx_valid delay flop 0.
- Reset has priority over every other event. Reset mid-transaction discards any partial bytes.
- Byte event: `rx_evt = rx_valid & ~rx_valid_q`, where rx_valid_q is rx_valid registered on clk.
  - A level held N cycles yields exactly one event.
  - A byte is captured from rx_data on the same clk edge where rx_evt=1.
- States and transitions:
  - WAIT_A: on rx_evt, alu_a <= rx_data, go to WAIT_B.
  - WAIT_B: on rx_evt, alu_b <= rx_data, go to WAIT_OP.
  - WAIT_OP: on rx_evt, check rx_data[OP_WIDTH-1:0]:
    - Legal: alu_op <= that value, go to EXEC.
    - Illegal: op_err=1 for exactly one cycle, alu_op unchanged, go to WAIT_A, no transmission.
  - EXEC (exactly 1 cycle, lets the ALU settle on the new alu_op): result_reg <= alu_result, go to SEND.
  - SEND:
    - While tx_busy=1: hold, tx_start=0.
    - First cycle with tx_busy=0: tx_data <= result_reg, tx_start=1 (registered, visible the following cycle for one cycle), go to WAIT_A.
- Legal opcodes: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SRA 0x03, SRL 0x02.
- Latency: from the opcode rx_evt edge to tx_start high is 3 clk cycles when tx_busy=0.
- Bytes during EXEC or SEND: dropped (alu_a/alu_b not modified) and overrun <= 1.
- alu_a/alu_b/alu_op hold their values after a transaction until overwritten by the next one.
- Operands are raw bytes with no width extension; result is truncated to DATA_WIDTH by the ALU.
- No timeout: a partial sequence waits indefinitely. Only reset resynchronises the byte order.
- rx_evt and tx_busy change in the same cycle in SEND: tx_busy is evaluated; the byte counts as an overrun.

Decomposition:
- Shared package uart_pkg holds:
  - opcode localparams (OP_ADD..OP_SRL);
  - the interface state enum {WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND}, 3 bits;
  - a function is_legal_op(op).
- The same package is later reused by the ALU and uart_tx.
- No sub-module: the edge detector is two lines inline. The ALU stays a separate top-level instance, not instantiated here.

Test Plan:
- Send rx bytes 0x05, 0x03, 0x20 (each rx_valid held 20 cycles), tx_busy=0 -> alu_a=0x05, alu_b=0x03, tx_data=0x08, a single one-cycle tx_start pulse 3 cycles after the opcode edge.
- Send 0x03, 0x05, 0x22 -> tx_data=0xFE; then 0xF0, 0x02, 0x03 (SRA) -> tx_data=0xFC.
- Send 0x01, 0x02, 0x3F -> op_err pulses exactly one cycle, no tx_start, state returns to WAIT_A; next triple 0x0F, 0xF0, 0x25 -> tx_data=0xFF.
- Hold tx_busy=1 for 50 cycles after the opcode -> tx_start stays 0 until the cycle after tx_busy falls, then pulses once. An extra rx byte during the wait sets overrun=1, and overrun stays 1.
- Send 0x11, 0x22, assert reset for 1 cycle, then 0x01, 0x01, 0x20 -> all outputs 0 after reset, tx_data=0x02 (the pre-reset bytes are discarded).
- rx_valid held high for 1000 cycles with rx_data=0x07 -> only alu_a captured, state=WAIT_B, no further advance.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART/ALU definitions: opcodes, interface FSM states, opcode legality.
package uart_pkg;

    localparam int unsigned OPCODE_WIDTH = 6;

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 6'h20;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 6'h22;
    localparam logic [OPCODE_WIDTH-1:0] OP_AND = 6'h24;
    localparam logic [OPCODE_WIDTH-1:0] OP_OR  = 6'h25;
    localparam logic [OPCODE_WIDTH-1:0] OP_XOR = 6'h26;
    localparam logic [OPCODE_WIDTH-1:0] OP_NOR = 6'h27;
    localparam logic [OPCODE_WIDTH-1:0] OP_SRA = 6'h03;
    localparam logic [OPCODE_WIDTH-1:0] OP_SRL = 6'h02;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4
    } if_state_t;

    // True when op is one of the opcodes the ALU implements.
    function automatic logic is_legal_op(input logic [OPCODE_WIDTH-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_alu_interface.sv
// Collects A, B, opcode bytes from uart_rx, runs the ALU, hands the result to uart_tx.
module uart_alu_interface
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OP_WIDTH   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [OP_WIDTH-1:0]   alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic                  op_err,
    output logic                  overrun
);

    if_state_t             state, state_d;
    logic                  rx_valid_q;
    logic                  rx_evt_c;
    logic [OP_WIDTH-1:0]   op_c;
    logic [DATA_WIDTH-1:0] result_reg, result_d;
    logic [DATA_WIDTH-1:0] alu_a_d, alu_b_d, tx_data_d;
    logic [OP_WIDTH-1:0]   alu_op_d;
    logic                  tx_start_d, op_err_d, overrun_d;

    // A held rx_valid level counts as a single byte: only its rising edge matters.
    assign rx_evt_c = rx_valid & ~rx_valid_q;
    assign op_c     = rx_data[OP_WIDTH-1:0];

    // State and output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAIT_A;
            rx_valid_q <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            result_reg <= '0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            op_err     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_d;
            rx_valid_q <= rx_valid;
            alu_a      <= alu_a_d;
            alu_b      <= alu_b_d;
            alu_op     <= alu_op_d;
            result_reg <= result_d;
            tx_data    <= tx_data_d;
            tx_start   <= tx_start_d;
            op_err     <= op_err_d;
            overrun    <= overrun_d;
        end
    end

    // Next-state and next-output logic; pulses default low, data defaults to hold.
    always_comb begin
        state_d    = state;
        alu_a_d    = alu_a;
        alu_b_d    = alu_b;
        alu_op_d   = alu_op;
        result_d   = result_reg;
        tx_data_d  = tx_data;
        tx_start_d = 1'b0;
        op_err_d   = 1'b0;
        overrun_d  = overrun;
        case (state)
            WAIT_A: begin
                if (rx_evt_c) begin
                    alu_a_d = rx_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (rx_evt_c) begin
                    alu_b_d = rx_data;
                    state_d = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (rx_evt_c) begin
                    if (is_legal_op(OPCODE_WIDTH'(op_c))) begin
                        alu_op_d = op_c;
                        state_d  = EXEC;
                    end else begin
                        op_err_d = 1'b1;
                        state_d  = WAIT_A;
                    end
                end
            end
            EXEC: begin
                // One cycle for the ALU to settle on the freshly registered opcode.
                result_d = alu_result;
                state_d  = SEND;
                if (rx_evt_c) overrun_d = 1'b1;
            end
            SEND: begin
                if (rx_evt_c) overrun_d = 1'b1;
                if (!tx_busy) begin
                    tx_data_d  = result_reg;
                    tx_start_d = 1'b1;
                    state_d    = WAIT_A;
                end
            end
            default: state_d = WAIT_A;
        endcase
    end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Randomized and directed bench for uart_alu_interface with a behavioural ALU and reference model.
module tb_uart_alu_interface;

    localparam int unsigned DW = 8;
    localparam int unsigned OW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic [DW-1:0] alu_a, alu_b, alu_result, tx_data;
    logic [OW-1:0] alu_op;
    logic          tx_start, tx_busy, op_err, overrun;

    int passed = 0;
    int total  = 0;

    uart_alu_interface #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .op_err     (op_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [5:0] legal_list [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

    function automatic bit legal_ref(input logic [5:0] op);
        for (int i = 0; i < 8; i++) if (legal_list[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Behavioural ALU: A op B, shifts move A by B positions.
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        logic signed [15:0] s;
        s = {{8{a[7]}}, a};
        case (op)
            6'h20:   return 8'(a + b);
            6'h22:   return 8'(a - b);
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return 8'(s >>> b);
            6'h02:   return 8'(a >> b);
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_result = alu_ref(alu_a, alu_b, alu_op);

    // Pulse monitor: counts rising edges and high cycles of tx_start and op_err.
    int          tx_cnt = 0, tx_high = 0, err_cnt = 0, err_high = 0;
    logic [7:0]  tx_last = 8'h00;
    int unsigned tx_cyc = 0;
    logic        tx_prev = 1'b0, err_prev = 1'b0;
    always @(negedge clk) begin
        if (tx_start) begin
            tx_high++;
            if (!tx_prev) begin
                tx_cnt++;
                tx_last = tx_data;
                tx_cyc  = cyc;
            end
        end
        if (op_err) begin
            err_high++;
            if (!err_prev) err_cnt++;
        end
        tx_prev  = tx_start;
        err_prev = op_err;
    end

    // Reference view of the ALU-facing registers.
    logic [7:0] exp_a = 8'h00, exp_b = 8'h00;
    logic [5:0] exp_op = 6'h00;

    task automatic send_byte(input logic [7:0] d, input int hold, output int unsigned edge_cyc);
        @(posedge clk); #1;
        rx_data  = d;
        rx_valid = 1'b1;
        edge_cyc = cyc;
        repeat (hold) @(posedge clk);
        #1 rx_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input int hold, input bit send_a, input string nm);
        int unsigned e;
        int          b_tx, b_txh, b_err, b_errh;
        bit          legal;
        logic [7:0]  exp_r;
        b_tx = tx_cnt; b_txh = tx_high; b_err = err_cnt; b_errh = err_high;
        if (send_a) begin
            send_byte(a, hold, e);
            exp_a = a;
        end
        send_byte(b, hold, e);
        exp_b = b;
        send_byte(op, hold, e);
        legal = legal_ref(op[5:0]);
        if (legal) exp_op = op[5:0];
        exp_r = alu_ref(exp_a, exp_b, exp_op);
        for (int i = 0; i < 20 && tx_cnt == b_tx; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        total++; if (alu_a !== exp_a) $display("FAIL %s alu_a got %h exp %h", nm, alu_a, exp_a); else passed++;
        total++; if (alu_b !== exp_b) $display("FAIL %s alu_b got %h exp %h", nm, alu_b, exp_b); else passed++;
        total++; if (alu_op !== exp_op) $display("FAIL %s alu_op got %h exp %h", nm, alu_op, exp_op); else passed++;
        if (legal) begin
            total++; if (tx_cnt !== b_tx + 1) $display("FAIL %s tx_start pulses got %0d exp 1", nm, tx_cnt - b_tx); else passed++;
            total++; if (tx_high !== b_txh + 1) $display("FAIL %s tx_start high cycles got %0d exp 1", nm, tx_high - b_txh); else passed++;
            total++; if (tx_last !== exp_r) $display("FAIL %s tx_data got %h exp %h", nm, tx_last, exp_r); else passed++;
            total++; if (tx_cyc - e !== 3) $display("FAIL %s latency got %0d exp 3", nm, tx_cyc - e); else passed++;
            total++; if (err_cnt !== b_err) $display("FAIL %s op_err got %0d pulses exp 0", nm, err_cnt - b_err); else passed++;
        end else begin
            total++; if (err_cnt !== b_err + 1) $display("FAIL %s op_err pulses got %0d exp 1", nm, err_cnt - b_err); else passed++;
            total++; if (err_high !== b_errh + 1) $display("FAIL %s op_err high cycles got %0d exp 1", nm, err_high - b_errh); else passed++;
            total++; if (tx_cnt !== b_tx) $display("FAIL %s tx_start got %0d pulses exp 0", nm, tx_cnt - b_tx); else passed++;
        end
    endtask

    task automatic check_all_zero(input string nm);
        total++; if (alu_a !== 8'h00) $display("FAIL %s alu_a got %h exp 00", nm, alu_a); else passed++;
        total++; if (alu_b !== 8'h00) $display("FAIL %s alu_b got %h exp 00", nm, alu_b); else passed++;
        total++; if (alu_op !== 6'h00) $display("FAIL %s alu_op got %h exp 00", nm, alu_op); else passed++;
        total++; if (tx_data !== 8'h00) $display("FAIL %s tx_data got %h exp 00", nm, tx_data); else passed++;
        total++; if (tx_start !== 1'b0) $display("FAIL %s tx_start got %b exp 0", nm, tx_start); else passed++;
        total++; if (op_err !== 1'b0) $display("FAIL %s op_err got %b exp 0", nm, op_err); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL %s overrun got %b exp 0", nm, overrun); else passed++;
    endtask

    task automatic test_reset;
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        exp_a = 8'h00; exp_b = 8'h00; exp_op = 6'h00;
        check_all_zero("reset");
    endtask

    task automatic test_directed;
        run_txn(8'h05, 8'h03, 8'h20, 20, 1'b1, "add");
        run_txn(8'h03, 8'h05, 8'h22, 20, 1'b1, "sub");
        run_txn(8'hF0, 8'h02, 8'h03, 20, 1'b1, "sra");
        run_txn(8'h01, 8'h02, 8'h3F, 20, 1'b1, "illegal");
        run_txn(8'h0F, 8'hF0, 8'h25, 20, 1'b1, "or_after_err");
    endtask

    task automatic test_busy;
        int unsigned e, m;
        int          b_tx, b_txh;
        logic [7:0]  exp_r;
        send_byte(8'h0A, 3, e); exp_a = 8'h0A;
        send_byte(8'h07, 3, e); exp_b = 8'h07;
        b_tx = tx_cnt; b_txh = tx_high;
        @(posedge clk); #1 tx_busy = 1'b1;
        send_byte(8'h26, 2, e); exp_op = 6'h26;
        exp_r = alu_ref(exp_a, exp_b, exp_op);
        repeat (10) @(posedge clk);
        send_byte(8'h55, 2, e);
        #1;
        total++; if (overrun !== 1'b1) $display("FAIL busy overrun got %b exp 1", overrun); else passed++;
        total++; if (alu_a !== exp_a) $display("FAIL busy dropped byte alu_a got %h exp %h", alu_a, exp_a); else passed++;
        repeat (34) @(posedge clk);
        total++; if (tx_cnt !== b_tx) $display("FAIL busy early tx_start got %0d pulses exp 0", tx_cnt - b_tx); else passed++;
        @(posedge clk); #1 tx_busy = 1'b0; m = cyc;
        for (int i = 0; i < 20 && tx_cnt == b_tx; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        total++; if (tx_cnt !== b_tx + 1) $display("FAIL busy tx_start pulses got %0d exp 1", tx_cnt - b_tx); else passed++;
        total++; if (tx_high !== b_txh + 1) $display("FAIL busy tx_start high cycles got %0d exp 1", tx_high - b_txh); else passed++;
        total++; if (tx_cyc !== m + 1) $display("FAIL busy release timing got %0d exp %0d", tx_cyc, m + 1); else passed++;
        total++; if (tx_last !== exp_r) $display("FAIL busy tx_data got %h exp %h", tx_last, exp_r); else passed++;
        run_txn(8'h30, 8'h11, 8'h24, 2, 1'b1, "after_busy");
        total++; if (overrun !== 1'b1) $display("FAIL overrun sticky got %b exp 1", overrun); else passed++;
    endtask

    task automatic test_reset_mid;
        int unsigned e;
        send_byte(8'h11, 2, e);
        send_byte(8'h22, 2, e);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        exp_a = 8'h00; exp_b = 8'h00; exp_op = 6'h00;
        check_all_zero("mid_reset");
        run_txn(8'h01, 8'h01, 8'h20, 3, 1'b1, "post_reset");
    endtask

    task automatic test_long_hold;
        int unsigned e;
        int          b_tx, b_err;
        b_tx = tx_cnt; b_err = err_cnt;
        send_byte(8'h07, 1000, e);
        exp_a = 8'h07;
        #1;
        total++; if (alu_a !== exp_a) $display("FAIL hold alu_a got %h exp %h", alu_a, exp_a); else passed++;
        total++; if (alu_b !== exp_b) $display("FAIL hold alu_b got %h exp %h", alu_b, exp_b); else passed++;
        total++; if (tx_cnt !== b_tx || err_cnt !== b_err)
            $display("FAIL hold activity got tx %0d err %0d exp 0 0", tx_cnt - b_tx, err_cnt - b_err); else passed++;
        run_txn(8'h00, 8'h09, 8'h20, 4, 1'b0, "hold_finish");
    endtask

    task automatic test_random;
        logic [7:0] a, b, op;
        for (int t = 0; t < 30; t++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 4) != 0) op = {2'($urandom), legal_list[$urandom_range(0, 7)]};
            else                           op = 8'($urandom);
            run_txn(a, b, op, int'($urandom_range(1, 6)), 1'b1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy();
        test_reset_mid();
        test_long_hold();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
